// File: rtl/vga_scan_controller.sv
// vga_scan_controller: 640x480@60 VGA scan engine.
// Generates the linear pixel address stream for the renderer, then delays sync/blank by the
// renderer read latency so RGB, sync and blank leave the block on the same cycle.
// Optional build macro VGA_TEST_PATTERN_EN adds iTestPattern, which swaps iPixel for eight
// vertical colour bars.
module vga_scan_controller #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic        iClock,
  input  logic        iReset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        iTestPattern,
`endif
  input  logic [23:0] iPixel,
  output logic [18:0] oAddress,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oBlank_n,
  output logic        oSync_n,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        oFrameStart
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  // Sync/blank pipeline depth: 1 for the address register, PIXEL_LATENCY for the renderer,
  // 1 for the RGB register.
  localparam int unsigned D       = PIXEL_LATENCY + 2;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [18:0]   addr_cnt;
  logic          h_last, v_last;
  logic          active, hs_raw, vs_raw;

  logic [D-1:0]  hs_pipe, vs_pipe, de_pipe;
  logic [23:0]   rgb_q;
  logic [23:0]   pixel_src;

  // Raw timing decoded from the counter state.
  always_comb begin
    h_last = (h_cnt == HW'(H_TOTAL - 1));
    v_last = (v_cnt == VW'(V_TOTAL - 1));
    active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_raw = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_raw = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
  end

  // Scan counters plus an incremental linear address that holds through blanking.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (h_last && v_last) begin
        addr_cnt <= '0;
      end else if (active) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  // Address stage: the renderer's frame timers depend on seeing 0 during blanking.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oAddress    <= '0;
      oFrameStart <= 1'b0;
    end else begin
      oAddress    <= active ? addr_cnt : '0;
      oFrameStart <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Alignment shift register; bit k holds the value from k+1 cycles ago.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      hs_pipe <= {hs_pipe[D-2:0], hs_raw};
      vs_pipe <= {vs_pipe[D-2:0], vs_raw};
      de_pipe <= {de_pipe[D-2:0], active};
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]                    bar_raw;
  logic [PIXEL_LATENCY:0][2:0]   bar_pipe;
  logic [2:0]                    bar_mask;

  // Bar index from comparisons against multiples of the bar width (no divider).
  always_comb begin
    bar_raw = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= HW'(i * BAR_W)) bar_raw = 3'(i);
    end
  end

  // Delay the bar index so it meets the RGB register on the same tap as de.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      bar_pipe <= '0;
    end else begin
      bar_pipe <= {bar_pipe[PIXEL_LATENCY-1:0], bar_raw};
    end
  end

  // Bar colour as {R,G,B} on/off mask: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    unique case (bar_pipe[PIXEL_LATENCY])
      3'd0:    bar_mask = 3'b111;
      3'd1:    bar_mask = 3'b110;
      3'd2:    bar_mask = 3'b011;
      3'd3:    bar_mask = 3'b010;
      3'd4:    bar_mask = 3'b101;
      3'd5:    bar_mask = 3'b100;
      3'd6:    bar_mask = 3'b001;
      default: bar_mask = 3'b000;
    endcase
    pixel_src = iTestPattern ? {{8{bar_mask[2]}}, {8{bar_mask[1]}}, {8{bar_mask[0]}}} : iPixel;
  end
`else
  // Renderer pixel is the only colour source.
  always_comb begin
    pixel_src = iPixel;
  end
`endif

  // RGB register: loads only for visible pixels so blanking always drives black.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= de_pipe[PIXEL_LATENCY] ? pixel_src : '0;
    end
  end

  assign oHSync   = hs_pipe[D-1];
  assign oVSync   = vs_pipe[D-1];
  assign oBlank_n = de_pipe[D-1];
  assign oSync_n  = 1'b0;
  assign oRed     = rgb_q[23:16];
  assign oGreen   = rgb_q[15:8];
  assign oBlue    = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Testbench for vga_scan_controller. Horizontal timing is the real 800-clock line; the
// vertical extent is shortened to 13 lines (6 active, FP 2, sync 2, BP 3) so several frames
// fit in a short run. n counts cycles from the one in which the counter sits at (0,0).
module tb_vga_scan_controller;

  localparam int VA    = 6;
  localparam int VFP   = 2;
  localparam int VSW   = 2;
  localparam int VBP   = 3;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int HT    = 800;
  localparam int FRAME = HT * VT;
  localparam int NVEC  = 27;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [23:0] iPixel;
  logic [18:0] oAddress;
  logic        oHSync, oVSync, oBlank_n, oSync_n, oFrameStart;
  logic [7:0]  oRed, oGreen, oBlue;
  logic        tp;

  always #20 iClock = ~iClock;

  vga_scan_controller #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
`ifdef VGA_TEST_PATTERN_EN
    .iTestPattern(tp),
`endif
    .iPixel      (iPixel),
    .oAddress    (oAddress),
    .oHSync      (oHSync),
    .oVSync      (oVSync),
    .oBlank_n    (oBlank_n),
    .oSync_n     (oSync_n),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oFrameStart (oFrameStart)
  );

  function automatic logic [23:0] pix(input logic [18:0] a);
    return {a[7:0], a[15:8], 8'hA5};
  endfunction

  // Renderer model: pixel for an address is returned two cycles after it appears.
  logic [18:0] a1, a2;
  always @(posedge iClock) begin
    a1 <= oAddress;
    a2 <= a1;
  end
  assign iPixel = pix(a2);

  typedef struct {
    int          n;
    logic [18:0] addr;
    logic        hs, vs, bn, fs;
    logic [23:0] rgb;
    string       name;
  } vec_t;

  vec_t vecs[NVEC];

  int errors = 0;
  int checks = 0;
  int n;
  int addr_bad, rgb_bad, hs_run, vs_run, last_fs, fs_count;
  logic [18:0] h1, h2, h3;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic longint exp_addr(input int cyc);
    int p, h, v;
    if (cyc < 1) return 0;
    p = cyc - 1;
    h = p % HT;
    v = (p / HT) % VT;
    return (h < 640 && v < VA) ? longint'(v * 640 + h) : 0;
  endfunction

  task automatic restart();
    n = 0; h1 = '0; h2 = '0; h3 = '0;
    hs_run = 0; vs_run = 0; last_fs = -1; fs_count = 0;
  endtask

  // Per-cycle observations at the current n.
  task automatic sample();
    if (longint'(oAddress) != exp_addr(n)) addr_bad++;
    if (!tp) begin
      if (oBlank_n) begin
        if ({oRed, oGreen, oBlue} !== pix(h3)) rgb_bad++;
      end else if ({oRed, oGreen, oBlue} !== 24'h0) begin
        rgb_bad++;
      end
    end
    if (oSync_n !== 1'b0) rgb_bad++;
    h3 = h2; h2 = h1; h1 = oAddress;
    if (!oHSync) hs_run++;
    else if (hs_run > 0) begin
      check("hsync_width", hs_run, 96);
      hs_run = 0;
    end
    if (!oVSync) vs_run++;
    else if (vs_run > 0) begin
      check("vsync_width", vs_run, VSW * HT);
      vs_run = 0;
    end
    if (oFrameStart) begin
      if (last_fs >= 0) check("frame_period", n - last_fs, FRAME);
      last_fs = n;
      fs_count++;
    end
  endtask

  task automatic tick();
    @(negedge iClock);
    n++;
    sample();
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic set_vec(input int i, input int cn, input int a, input logic hs, input logic vs,
                         input logic bn, input logic fs, input logic [23:0] rgb,
                         input string name);
    vecs[i].n = cn; vecs[i].addr = 19'(a); vecs[i].hs = hs; vecs[i].vs = vs;
    vecs[i].bn = bn; vecs[i].fs = fs; vecs[i].rgb = rgb; vecs[i].name = name;
  endtask

  initial begin
    set_vec( 0,     0,    0, 1, 1, 0, 0, 24'h000000, "reset_state");
    set_vec( 1,     1,    0, 1, 1, 0, 1, 24'h000000, "frame_start");
    set_vec( 2,     2,    1, 1, 1, 0, 0, 24'h000000, "addr1");
    set_vec( 3,     3,    2, 1, 1, 0, 0, 24'h000000, "pre_visible");
    set_vec( 4,     4,    3, 1, 1, 1, 0, 24'h0000A5, "first_visible");
    set_vec( 5,     5,    4, 1, 1, 1, 0, 24'h0100A5, "second_visible");
    set_vec( 6,   640,  639, 1, 1, 1, 0, 24'h7C02A5, "last_addr_line0");
    set_vec( 7,   641,    0, 1, 1, 1, 0, 24'h7D02A5, "addr_blank_line0");
    set_vec( 8,   643,    0, 1, 1, 1, 0, 24'h7F02A5, "last_visible_line0");
    set_vec( 9,   644,    0, 1, 1, 0, 0, 24'h000000, "blank_after_line0");
    set_vec(10,   659,    0, 1, 1, 0, 0, 24'h000000, "hs_pre");
    set_vec(11,   660,    0, 0, 1, 0, 0, 24'h000000, "hs_start");
    set_vec(12,   755,    0, 0, 1, 0, 0, 24'h000000, "hs_end");
    set_vec(13,   756,    0, 1, 1, 0, 0, 24'h000000, "hs_after");
    set_vec(14,   801,  640, 1, 1, 0, 0, 24'h000000, "line1_addr");
    set_vec(15,   804,  643, 1, 1, 1, 0, 24'h8002A5, "line1_visible");
    set_vec(16,  4640, 3839, 1, 1, 1, 0, 24'hFC0EA5, "last_active_addr");
    set_vec(17,  4641,    0, 1, 1, 1, 0, 24'hFD0EA5, "after_last_addr");
    set_vec(18,  6403,    0, 1, 1, 0, 0, 24'h000000, "vs_pre");
    set_vec(19,  6404,    0, 1, 0, 0, 0, 24'h000000, "vs_start");
    set_vec(20,  8003,    0, 1, 0, 0, 0, 24'h000000, "vs_end");
    set_vec(21,  8004,    0, 1, 1, 0, 0, 24'h000000, "vs_after");
    set_vec(22, 10400,    0, 1, 1, 0, 0, 24'h000000, "pre_frame2");
    set_vec(23, 10401,    0, 1, 1, 0, 1, 24'h000000, "frame2_start");
    set_vec(24, 10402,    1, 1, 1, 0, 0, 24'h000000, "frame2_addr1");
    set_vec(25, 10403,    2, 1, 1, 0, 0, 24'h000000, "frame2_pre_visible");
    set_vec(26, 10404,    3, 1, 1, 1, 0, 24'h0000A5, "frame2_first_visible");

    addr_bad = 0; rgb_bad = 0; tp = 1'b0;
    iReset = 1'b1;
    restart();
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    iReset = 1'b0;
    restart();
    sample();

    for (int i = 0; i < NVEC; i++) begin
      run_to(vecs[i].n);
      check({vecs[i].name, ".addr"}, oAddress, vecs[i].addr);
      check({vecs[i].name, ".hsync"}, oHSync, vecs[i].hs);
      check({vecs[i].name, ".vsync"}, oVSync, vecs[i].vs);
      check({vecs[i].name, ".blank_n"}, oBlank_n, vecs[i].bn);
      check({vecs[i].name, ".frame_start"}, oFrameStart, vecs[i].fs);
      check({vecs[i].name, ".rgb"}, {oRed, oGreen, oBlue}, vecs[i].rgb);
    end

`ifdef VGA_TEST_PATTERN_EN
    tp = 1'b1;
    run_to(FRAME + 4);
    check("bar_px0", {oRed, oGreen, oBlue}, 24'hFFFFFF);
    run_to(FRAME + 84);
    check("bar_px80", {oRed, oGreen, oBlue}, 24'hFFFF00);
    run_to(FRAME + 564);
    check("bar_px560", {oRed, oGreen, oBlue}, 24'h000000);
    check("bar_blank_n", oBlank_n, 1'b1);
    tp = 1'b0;
`endif

    // Mid-frame reset at counter (300,3) of the second frame.
    run_to(FRAME + 3 * HT + 300);
    check("pre_reset_addr", oAddress, 3 * 640 + 299);
    iReset = 1'b1;
    @(negedge iClock);
    check("mid_reset.addr", oAddress, 0);
    check("mid_reset.hsync", oHSync, 1);
    check("mid_reset.vsync", oVSync, 1);
    check("mid_reset.blank_n", oBlank_n, 0);
    check("mid_reset.rgb", {oRed, oGreen, oBlue}, 24'h0);
    check("mid_reset.frame_start", oFrameStart, 0);
    iReset = 1'b0;
    restart();
    sample();
    tick();
    check("restart.frame_start", oFrameStart, 1);
    check("restart.addr", oAddress, 0);
    run_to(4);
    check("restart.first_visible", oBlank_n, 1);
    run_to(FRAME + 2);
    check("restart.frame_pulses", fs_count, 2);

    check("addr_stream_mismatches", addr_bad, 0);
    check("rgb_alignment_mismatches", rgb_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
